// File: rtl/imem_loader_pkg.sv
// ----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the boot-time instruction-memory loader:
//   default geometry, header length and the loader FSM state encoding.
//   No ports (package).
// ----------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int LDR_ADDR_W    = 64;   // matches PC width
  localparam int LDR_MAX_WORDS = 256;  // instruction memory capacity, words
  localparam int LDR_CNT_W     = 16;   // word-count header / counter width
  localparam int LDR_HDR_BYTES = 2;    // little-endian word-count header

  // 3-bit state encoding; exported on dbg_state so checkers can bind to it.
  typedef enum logic [2:0] {
    ST_HDR0  = 3'd0,
    ST_HDR1  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } ldr_state_e;

endpackage

// File: rtl/imem_loader_word_packer.sv
// ----------------------------------------------------------------------------
// word_packer
//   Packs little-endian bytes into a 32-bit word. A 2-bit lane counter tracks
//   the byte position; the first three bytes are shifted into a 24-bit
//   register and the fourth byte is combined on the fly, so the full word is
//   available in the same cycle its last byte is strobed.
// Ports
//   clock      in   1   rising-edge clock
//   reset      in   1   synchronous, active-high; empties the packer
//   data_byte  in   8   incoming byte
//   strobe     in   1   data_byte is consumed this cycle
//   clear      in   1   synchronous flush of lane counter and partial word
//   word       out  32  {data_byte, previous three bytes}; valid with word_full
//   word_full  out  1   strobe on lane 3: word holds a complete instruction
// ----------------------------------------------------------------------------
module word_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  data_byte,
  input  logic        strobe,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  lane;
  logic [23:0] partial;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      lane    <= 2'd0;
      partial <= 24'd0;
    end else if (strobe) begin
      lane    <= lane + 2'd1;
      // Shift right so that after three bytes partial = {b2, b1, b0}.
      partial <= {data_byte, partial[23:8]};
    end
  end

  assign word      = {data_byte, partial};
  assign word_full = strobe && (lane == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//   Boot-time program loader in front of the single-cycle CPU. Takes a byte
//   stream (2-byte little-endian word count N, then 4*N instruction bytes,
//   LSB first), writes each word into instruction memory from byte address 0
//   and holds the CPU's PC register in reset until the whole program is in.
//
// Handshake: a byte transfers on every rising edge where s_valid && s_ready.
//   s_ready is registered and depends only on loader state, never on s_valid;
//   the source may drop s_valid at any time and partial words are held.
//
// Ports
//   clock       in   1       system clock, rising edge
//   reset       in   1       synchronous, active-high; wins over everything
//   s_data      in   8       stream byte
//   s_valid     in   1       s_data valid
//   s_ready     out  1       loader accepts a byte this cycle
//   imem_we     out  1       instruction-memory write strobe (1-cycle pulse)
//   imem_addr   out  ADDR_W  byte address of the word being written
//   imem_wdata  out  32      instruction word
//   cpu_reset   out  1       PC register reset; 1 until the load completes
//   done        out  1       load complete (sticky until reset)
//   error       out  1       header exceeded MAX_WORDS (sticky until reset)
//   word_count  out  CNT_W   words written so far
//   dbg_state   out  3       current FSM state (ldr_state_e encoding)
// ----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = LDR_ADDR_W,
  parameter int MAX_WORDS = LDR_MAX_WORDS,
  parameter int CNT_W     = LDR_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  word_count,
  output logic [2:0]        dbg_state
);

  localparam int                 HDR_BITS = LDR_HDR_BYTES * 8;
  localparam logic [HDR_BITS-1:0] MAX_N   = HDR_BITS'(MAX_WORDS);

  ldr_state_e          state;
  logic [HDR_BITS-1:0] n;          // word count from the header
  logic [HDR_BITS-1:0] hdr_n;      // header value as seen in HDR1
  logic [CNT_W-1:0]    next_count;
  logic                accept;
  logic                pk_strobe;
  logic                pk_clear;
  logic [31:0]         pk_word;
  logic                pk_full;

  assign accept     = s_valid && s_ready;
  assign hdr_n      = {s_data, n[7:0]};
  assign next_count = word_count + CNT_W'(1);
  assign dbg_state  = state;

  // Only payload bytes go to the packer; keeping it flushed while the header
  // is parsed guarantees every word starts at lane 0.
  assign pk_strobe  = accept && (state == ST_LOAD);
  assign pk_clear   = (state == ST_HDR0) || (state == ST_HDR1);

  word_packer u_packer (
    .clock     (clock),
    .reset     (reset),
    .data_byte (s_data),
    .strobe    (pk_strobe),
    .clear     (pk_clear),
    .word      (pk_word),
    .word_full (pk_full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_HDR0;
      n          <= '0;
      word_count <= '0;
      s_ready    <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_HDR0: begin
          if (accept) begin
            n[7:0] <= s_data;
            state  <= ST_HDR1;
          end
        end

        ST_HDR1: begin
          if (accept) begin
            n <= hdr_n;
            if (hdr_n == '0) begin
              // Empty program: release the CPU straight away.
              state     <= ST_DONE;
              s_ready   <= 1'b0;
              cpu_reset <= 1'b0;
              done      <= 1'b1;
            end else if (hdr_n > MAX_N) begin
              state   <= ST_ERROR;
              s_ready <= 1'b0;
              error   <= 1'b1;
            end else begin
              state <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          // pk_full implies a byte was accepted this cycle on lane 3.
          if (pk_full) begin
            state      <= ST_WRITE;
            s_ready    <= 1'b0;
            imem_we    <= 1'b1;
            imem_addr  <= ADDR_W'({word_count, 2'b00});
            imem_wdata <= pk_word;
          end
        end

        ST_WRITE: begin
          // The write pulse is visible during this cycle; count it on exit.
          word_count <= next_count;
          if (next_count == CNT_W'(n)) begin
            state     <= ST_DONE;
            cpu_reset <= 1'b0;
            done      <= 1'b1;
          end else begin
            state   <= ST_LOAD;
            s_ready <= 1'b1;
          end
        end

        ST_DONE, ST_ERROR: begin
          // Terminal until reset; s_ready already low.
        end

        default: begin
          state   <= ST_HDR0;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [15:0] word_count;
  logic [2:0]  dbg_state;

  always #5 clock = ~clock;

  imem_loader dut (
    .clock      (clock),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error),
    .word_count (word_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model keeps every byte accepted since reset and derives the expected
  // outputs from the stream format directly.
  logic [7:0]  bq[$];
  int          m_wc = 0;     // words whose write pulse has completed
  bit          m_we = 0;     // write pulse expected this cycle
  bit          armed = 0;
  logic [95:0] exp_q[$];     // {addr, data} of expected writes
  logic [63:0] wa_log[$];
  logic [31:0] wd_log[$];

  function automatic int m_n();
    return int'({bq[1], bq[0]});
  endfunction

  function automatic bit m_error();
    return (bq.size() >= 2) && (m_n() > 256);
  endfunction

  function automatic bit m_done();
    return (bq.size() >= 2) && !m_error() && (m_wc == m_n());
  endfunction

  function automatic bit m_ready();
    return !m_we && !m_done() && !m_error();
  endfunction

  initial forever begin
    @(posedge clock);
    if (reset) begin
      bq.delete();
      exp_q.delete();
      m_wc  = 0;
      m_we  = 0;
      armed = 1;
    end else if (armed) begin
      bit acc;
      int k;
      acc = s_valid && m_ready();
      if (m_we) begin
        m_we = 0;
        m_wc++;
      end
      if (acc) begin
        bq.push_back(s_data);
        if (bq.size() >= 6 && ((bq.size() - 2) % 4) == 0) begin
          k = (bq.size() - 2) / 4 - 1;
          exp_q.push_back({64'(k * 4), bq[4*k+5], bq[4*k+4], bq[4*k+3], bq[4*k+2]});
          m_we = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clock);
    if (armed) begin
      chk("s_ready",    64'(s_ready),    64'(m_ready()));
      chk("imem_we",    64'(imem_we),    64'(m_we));
      chk("done",       64'(done),       64'(m_done()));
      chk("error",      64'(error),      64'(m_error()));
      chk("cpu_reset",  64'(cpu_reset),  64'(!m_done()));
      chk("word_count", 64'(word_count), 64'(m_wc));
      if (imem_we === 1'b1) begin
        logic [95:0] e;
        wa_log.push_back(imem_addr);
        wd_log.push_back(imem_wdata);
        chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("write_addr", imem_addr,        e[95:32]);
          chk("write_data", 64'(imem_wdata),  64'(e[31:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    wa_log.delete();
    wd_log.delete();
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    bit took = 0;
    s_data  = b;
    s_valid = 1'b1;
    while (!took && waited < 40) begin
      @(posedge clock);
      took = s_ready;
      waited++;
      #1;
    end
    chk("byte_accepted", 64'(took), 64'd1);
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) @(posedge clock);
      #1;
    end
  endtask

  task automatic send_stream(input logic [7:0] bytes[$], input int gap);
    foreach (bytes[i]) send_byte(bytes[i], gap);
    s_valid = 1'b0;
  endtask

  task automatic hold_extra(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      s_data  = 8'($urandom_range(0, 255));
      s_valid = 1'b1;
      @(posedge clock);
      #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic check_final(input string tag, input int wc, input bit dn,
                             input bit er, input int nwr);
    chk({tag, ".word_count"}, 64'(word_count), 64'(wc));
    chk({tag, ".done"},       64'(done),       64'(dn));
    chk({tag, ".error"},      64'(error),      64'(er));
    chk({tag, ".cpu_reset"},  64'(cpu_reset),  64'(!dn));
    chk({tag, ".s_ready"},    64'(s_ready),    64'd0);
    chk({tag, ".writes"},     64'(wa_log.size()), 64'(nwr));
  endtask

  task automatic check_prog1(input string tag);
    chk({tag, ".w0_addr"}, wa_log.size() > 0 ? wa_log[0] : 64'hx, 64'h0);
    chk({tag, ".w0_data"}, wd_log.size() > 0 ? 64'(wd_log[0]) : 64'hx, 64'hD280_0020);
    chk({tag, ".w1_addr"}, wa_log.size() > 1 ? wa_log[1] : 64'hx, 64'h4);
    chk({tag, ".w1_data"}, wd_log.size() > 1 ? 64'(wd_log[1]) : 64'hx, 64'h8B00_0041);
    check_final(tag, 2, 1'b1, 1'b0, 2);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] prog1[$] = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h80, 8'hD2,
                           8'h41, 8'h00, 8'h00, 8'h8B};

  initial begin
    do_reset();

    // Reset values.
    chk("rst.s_ready",    64'(s_ready),    64'd1);
    chk("rst.imem_we",    64'(imem_we),    64'd0);
    chk("rst.imem_addr",  imem_addr,       64'd0);
    chk("rst.imem_wdata", 64'(imem_wdata), 64'd0);
    chk("rst.cpu_reset",  64'(cpu_reset),  64'd1);
    chk("rst.done",       64'(done),       64'd0);
    chk("rst.error",      64'(error),      64'd0);
    chk("rst.word_count", 64'(word_count), 64'd0);

    // 1: two-word program, back to back.
    send_stream(prog1, 0);
    idle(4);
    check_prog1("t1");

    // 2: empty program completes on the cycle after the header.
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    s_valid = 1'b0;
    chk("t2.done_next_cycle", 64'(done), 64'd1);
    idle(3);
    check_final("t2", 0, 1'b1, 1'b0, 0);

    // 3: oversize header (257 words).
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    hold_extra(12);
    idle(3);
    check_final("t3", 0, 1'b0, 1'b1, 0);

    // 4: same program with 3-cycle gaps between every byte.
    do_reset();
    send_stream(prog1, 3);
    idle(4);
    check_prog1("t4");

    // 5: reset mid-word (colliding with a valid byte), then a 1-word program.
    do_reset();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h20, 0);
    send_byte(8'h00, 0);
    reset   = 1'b1;
    s_data  = 8'h80;
    s_valid = 1'b1;
    @(posedge clock);
    #1;
    reset   = 1'b0;
    s_valid = 1'b0;
    chk("t5.after_reset.cpu_reset",  64'(cpu_reset),  64'd1);
    chk("t5.after_reset.word_count", 64'(word_count), 64'd0);
    wa_log.delete();
    wd_log.delete();
    idle(2);
    send_stream('{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 0);
    idle(4);
    chk("t5.w0_addr", wa_log.size() > 0 ? wa_log[0] : 64'hx, 64'h0);
    chk("t5.w0_data", wd_log.size() > 0 ? 64'(wd_log[0]) : 64'hx, 64'hDEAD_BEEF);
    check_final("t5", 1, 1'b1, 1'b0, 1);

    // 6: keep streaming past the end of the program.
    do_reset();
    send_stream(prog1, 0);
    hold_extra(16);
    idle(2);
    check_prog1("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (compared %0d, mismatched %0d)", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
